// File: rtl/tri_fetch_sched.sv
// Sequencer for the serial vertex converter: fetch 6 words, start, shift, await finish, present.
// Optional `DEGEN_SKIP_EN drops triangles with two equal vertices. Converter reset = ~i_reset.
module tri_fetch_sched #(
  parameter int unsigned WIDTH       = 9,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned FIN_TIMEOUT = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_go,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CNT_W-1:0]  i_tri_count,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [WIDTH:0]    i_mem_data,
  output logic              o_conv_start,
  output logic [WIDTH:0]    o_conv_inp,
  input  logic              i_conv_finish,
  output logic              o_tri_valid,
  input  logic              i_tri_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_skip_cnt
);

  typedef enum logic [2:0] {StIdle, StFetch, StStart, StShift, StWaitFin, StPresent} state_e;

  state_e            r_state, w_state_next;
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] r_tri_addr;
  logic [CNT_W-1:0]  r_count, r_idx;
  logic [WIDTH:0]    r_buf [6];
  logic [WIDTH:0]    r_conv_inp;
  logic              r_busy, r_done, r_err;

  logic             w_go, w_fetch_last, w_degen, w_skip, w_handshake, w_timeout, w_last_tri;
  logic             w_tri_end;
  logic [CNT_W-1:0] w_idx_inc;

  assign w_go         = (r_state == StIdle) && i_go;
  assign w_fetch_last = (r_state == StFetch) && (r_cnt == 8'd6);
  assign w_skip       = w_fetch_last && w_degen;
  assign w_handshake  = (r_state == StPresent) && i_tri_ready;
  assign w_timeout    = (r_state == StWaitFin) && !i_conv_finish &&
                        (r_cnt == 8'(FIN_TIMEOUT - 1));
  assign w_idx_inc    = r_idx + CNT_W'(1);
  assign w_last_tri   = (w_idx_inc == r_count);
  assign w_tri_end    = w_handshake || w_skip;

`ifdef DEGEN_SKIP_EN
  logic [CNT_W-1:0] r_skip_cnt;

  // y3 arrives on the memory bus in the last FETCH cycle, so compare it directly.
  assign w_degen = ((r_buf[0] == r_buf[2]) && (r_buf[1] == r_buf[3])) ||
                   ((r_buf[0] == r_buf[4]) && (r_buf[1] == i_mem_data)) ||
                   ((r_buf[2] == r_buf[4]) && (r_buf[3] == i_mem_data));

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_skip_cnt <= '0;
    end else if (w_skip && (r_skip_cnt != {CNT_W{1'b1}})) begin
      r_skip_cnt <= r_skip_cnt + CNT_W'(1);
    end
  end

  assign o_skip_cnt = r_skip_cnt;
`else
  assign w_degen    = 1'b0;
  assign o_skip_cnt = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (i_go && (i_tri_count != '0)) w_state_next = StFetch;
      StFetch:   if (w_fetch_last) begin
                   if (w_degen) w_state_next = w_last_tri ? StIdle : StFetch;
                   else         w_state_next = StStart;
                 end
      StStart:   w_state_next = StShift;
      StShift:   if (r_cnt == 8'd5) w_state_next = StWaitFin;
      StWaitFin: begin
                   if (i_conv_finish)  w_state_next = StPresent;
                   else if (w_timeout) w_state_next = StIdle;
                 end
      StPresent: if (i_tri_ready) w_state_next = w_last_tri ? StIdle : StFetch;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt      <= '0;
      r_tri_addr <= '0;
      r_count    <= '0;
      r_idx      <= '0;
      r_conv_inp <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      for (int i = 0; i < 6; i++) r_buf[i] <= '0;
    end else begin
      r_done <= 1'b0;
      r_cnt  <= ((w_state_next != r_state) || w_skip) ? '0 : r_cnt + 8'd1;
      if (w_go) begin
        r_tri_addr <= i_base_addr;
        r_count    <= i_tri_count;
        r_idx      <= '0;
        r_err      <= 1'b0;
        r_busy     <= (i_tri_count != '0);
        r_done     <= (i_tri_count == '0);
      end
      // Word k was read in FETCH cycle k and is on the bus in cycle k+1.
      if ((r_state == StFetch) && (r_cnt != 8'd0) && (r_cnt <= 8'd6)) begin
        r_buf[r_cnt[2:0] - 3'd1] <= i_mem_data;
      end
      if (r_state == StStart) r_conv_inp <= r_buf[0];
      if ((r_state == StShift) && (r_cnt < 8'd5)) r_conv_inp <= r_buf[r_cnt[2:0] + 3'd1];
      if (w_tri_end) begin
        r_idx      <= w_idx_inc;
        r_tri_addr <= r_tri_addr + ADDR_W'(6);
        if (w_last_tri) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
      if (w_timeout) begin
        r_err  <= 1'b1;
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  always_comb begin
    o_mem_rd     = (r_state == StFetch) && (r_cnt < 8'd6);
    o_mem_addr   = o_mem_rd ? (r_tri_addr + ADDR_W'(r_cnt[2:0])) : '0;
    o_conv_start = (r_state == StStart);
    o_tri_valid  = (r_state == StPresent);
    o_conv_inp   = r_conv_inp;
    o_busy       = r_busy;
    o_done       = r_done;
    o_err        = r_err;
  end

endmodule

// File: tb/tb_tri_fetch_sched.sv
// Scoreboard bench for tri_fetch_sched with behavioural vertex memory and converter models.
module tb_tri_fetch_sched;
  localparam int WIDTH = 9, ADDR_W = 10, CNT_W = 8;

  logic              clk = 1'b0, reset = 1'b0, go = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  tri_count = '0;
  logic              mem_rd, conv_start, tri_valid, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH:0]    mem_data = '0, conv_inp;
  logic              conv_finish, tri_ready = 1'b1;
  logic [CNT_W-1:0]  skip_cnt;

  tri_fetch_sched dut (
    .i_clk(clk), .i_reset(reset), .i_go(go), .i_base_addr(base_addr), .i_tri_count(tri_count),
    .o_mem_rd(mem_rd), .o_mem_addr(mem_addr), .i_mem_data(mem_data),
    .o_conv_start(conv_start), .o_conv_inp(conv_inp), .i_conv_finish(conv_finish),
    .o_tri_valid(tri_valid), .i_tri_ready(tri_ready), .o_busy(busy), .o_done(done),
    .o_err(err), .o_skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;
  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Synchronous vertex memory: data one cycle after the read strobe.
  logic [WIDTH:0] mem [1024];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  // Converter model: samples start, then one word per SHIFT cycle, finish in the next cycle.
  logic [WIDTH:0] cv_word [6];
  int   cv_k = 0, n_start = 0;
  logic cv_fin = 1'b0, nofin = 1'b0;
  assign conv_finish = cv_fin;
  always @(posedge clk) begin
    if (!reset) begin
      cv_k   <= 0;
      cv_fin <= 1'b0;
    end else begin
      cv_fin <= 1'b0;
      if (conv_start) begin
        cv_k    <= 1;
        n_start <= n_start + 1;
      end else if (cv_k >= 1 && cv_k <= 6) begin
        cv_word[cv_k-1] <= conv_inp;
        cv_k            <= (cv_k == 6) ? 0 : cv_k + 1;
        if (cv_k == 6) cv_fin <= !nofin;
      end
    end
  end

  typedef struct { int cyc; logic [59:0] w; } tri_t;
  typedef struct { int cyc; logic e; } done_t;
  tri_t  exp_tri[$];
  done_t exp_done[$];
  tri_t  mt;
  done_t md;

  always @(negedge clk) begin
    if (tri_valid && tri_ready) begin
      if (exp_tri.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_tri: got handshake at cycle %0d, required none", cyc);
      end else begin
        mt = exp_tri.pop_front();
        check("tri_cycle", 64'(cyc), 64'(mt.cyc));
        check("tri_words", {4'h0, cv_word[0], cv_word[1], cv_word[2], cv_word[3], cv_word[4],
                            cv_word[5]}, {4'h0, mt.w});
      end
    end
    if (done) begin
      if (exp_done.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
      end else begin
        md = exp_done.pop_front();
        check("done_cycle", 64'(cyc), 64'(md.cyc));
        check("done_err", 64'(err), 64'(md.e));
        check("done_busy", 64'(busy), 64'd0);
      end
    end
  end

  task automatic run_go(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n, output int g);
    @(posedge clk); #1;
    base_addr = b; tri_count = n; go = 1'b1; g = cyc;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic at_cycle(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_tri(input int c, input logic [59:0] w);
    tri_t t;
    t.cyc = c; t.w = w;
    exp_tri.push_back(t);
  endtask

  task automatic push_done(input int c, input logic e);
    done_t d;
    d.cyc = c; d.e = e;
    exp_done.push_back(d);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_outs"}, {mem_rd, conv_start, tri_valid, busy, done, err},  6'b0);
    check({name, "_addr"}, 64'(mem_addr), 64'd0);
    check({name, "_inp"}, 64'(conv_inp), 64'd0);
    check({name, "_skip"}, 64'(skip_cnt), 64'd0);
  endtask

  task automatic check_drained(input string name);
    check({name, "_tri_q"}, 64'(exp_tri.size()), 64'd0);
    check({name, "_done_q"}, 64'(exp_done.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    int g, s0;
    logic [59:0] w;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 6; i++) cv_word[i] = '0;
    for (int i = 0; i < 6; i++) mem[16 + i] = 10'(i + 1);
    for (int i = 0; i < 18; i++) mem[(10'h3FC + i) % 1024] = 10'(10'h40 + i);
    for (int i = 0; i < 12; i++) mem[10'h100 + i] = 10'(10'h200 + i);
    for (int i = 0; i < 6; i++) mem[10'h020 + i] = 10'(10'h11 + i);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 reset = 1'b1;

    // Single triangle, 16-cycle latency to tri_valid.
    s0 = n_start;
    run_go(10'h010, 8'd1, g);
    push_tri(g + 16, {10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6});
    push_done(g + 17, 1'b0);
    at_cycle(g + 1);
    check("busy_set", 64'(busy), 64'd1);
    at_cycle(g + 22);
    check("a_starts", 64'(n_start - s0), 64'd1);
    check_drained("a");

    // Address wrap, three back-to-back triangles.
    run_go(10'h3FC, 8'd3, g);
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 6; k++) w[(5 - k) * 10 +: 10] = 10'(10'h40 + 6 * t + k);
      push_tri(g + 16 + 16 * t, w);
    end
    push_done(g + 49, 1'b0);
    at_cycle(g + 55);
    check_drained("wrap");

    // Downstream stall for 10 cycles; a go during the stall is ignored.
    tri_ready = 1'b0;
    run_go(10'h100, 8'd2, g);
    push_tri(g + 26, {10'h200, 10'h201, 10'h202, 10'h203, 10'h204, 10'h205});
    push_tri(g + 42, {10'h206, 10'h207, 10'h208, 10'h209, 10'h20A, 10'h20B});
    push_done(g + 43, 1'b0);
    at_cycle(g + 20);
    @(posedge clk); #1 base_addr = 10'h000; tri_count = 8'd5; go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    at_cycle(g + 25);
    check("stall_valid", 64'(tri_valid), 64'd1);
    check("stall_no_fetch", 64'(mem_rd), 64'd0);
    check("stall_busy", 64'(busy), 64'd1);
    @(posedge clk); #1 tri_ready = 1'b1;
    at_cycle(g + 50);
    check_drained("stall");

    // Converter never finishes: error after four WAIT_FIN cycles.
    nofin = 1'b1;
    run_go(10'h020, 8'd1, g);
    push_done(g + 19, 1'b1);
    at_cycle(g + 18);
    check("err_not_yet", 64'(err), 64'd0);
    at_cycle(g + 22);
    check("err_sticky", 64'(err), 64'd1);
    check_drained("tmo");
    nofin = 1'b0;
    run_go(10'h010, 8'd1, g);
    push_tri(g + 16, {10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6});
    push_done(g + 17, 1'b0);
    at_cycle(g + 1);
    check("err_cleared", 64'(err), 64'd0);
    at_cycle(g + 20);
    check_drained("retry");

    // Zero-length batch.
    run_go(10'h000, 8'd0, g);
    push_done(g + 1, 1'b0);
    at_cycle(g + 3);
    check("zero_busy", 64'(busy), 64'd0);
    check_drained("zero");

`ifdef DEGEN_SKIP_EN
    // Triangle 1 has (x1,y1) = (x3,y3) = (7,7) and is skipped.
    for (int k = 0; k < 6; k++) mem[10'h140 + k] = 10'(10'h101 + k);
    mem[10'h146] = 10'd7; mem[10'h147] = 10'd7; mem[10'h148] = 10'd1;
    mem[10'h149] = 10'd2; mem[10'h14A] = 10'd7; mem[10'h14B] = 10'd7;
    for (int k = 0; k < 6; k++) mem[10'h14C + k] = 10'(10'h111 + k);
    s0 = n_start;
    run_go(10'h140, 8'd3, g);
    push_tri(g + 16, {10'h101, 10'h102, 10'h103, 10'h104, 10'h105, 10'h106});
    push_tri(g + 39, {10'h111, 10'h112, 10'h113, 10'h114, 10'h115, 10'h116});
    push_done(g + 40, 1'b0);
    at_cycle(g + 45);
    check("degen_starts", 64'(n_start - s0), 64'd2);
    check("degen_skip_cnt", 64'(skip_cnt), 64'd1);
    check_drained("degen");
`else
    check("skip_tied", 64'(skip_cnt), 64'd0);
`endif

    // Reset for two cycles in the middle of SHIFT aborts the batch.
    run_go(10'h010, 8'd2, g);
    at_cycle(g + 9);
    @(posedge clk); #1 reset = 1'b0;
    at_cycle(g + 11);
    check_idle_outputs("midrst");
    @(posedge clk); #1 reset = 1'b1;
    at_cycle(g + 12);
    check_idle_outputs("midrst_after");
    at_cycle(g + 40);
    check_drained("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tri_fetch_sched.md
Name: tri_fetch_sched

Overview:
Controller that sequences the serial-to-parallel vertex converter in the GPU front end. It fetches six coordinate words per triangle (x1,y1,x2,y2,x3,y3) from the synchronous vertex memory into a local buffer. It then pulses the converter's start and streams the words into its serial input with the cycle alignment the converter requires. When the converter raises finish, it presents the triangle downstream with a valid/ready handshake, and repeats for tri_count triangles.

Parameters:
WIDTH, 9, coordinate word is WIDTH+1 bits (matches converter)
ADDR_W, 10, vertex memory address width
CNT_W, 8, triangle counter width
FIN_TIMEOUT, 4, max cycles to wait in WAIT_FIN before error

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-low: reset=0 at a rising edge resets the block
go  input  1  start a batch; sampled only in IDLE
base_addr  input  ADDR_W  address of word x1 of triangle 0; latched on go
tri_count  input  CNT_W  number of triangles; latched on go
mem_rd  output  1  memory read strobe
mem_addr  output  ADDR_W  read address
mem_data  input  WIDTH+1  read data, valid exactly 1 cycle after mem_rd
conv_start  output  1  one-cycle start pulse to converter
conv_inp  output  WIDTH+1  serial word to converter, registered
conv_finish  input  1  converter finish
tri_valid  output  1  converter outputs x1..y3 hold a new triangle
tri_ready  input  1  downstream accepts triangle
busy  output  1  batch in progress
done  output  1  one-cycle pulse at batch end
err  output  1  sticky: finish timeout; cleared by reset or accepted go
skip_cnt  output  CNT_W  skipped triangles (feature only, else tied 0)

Behaviour:
- Reset (all outputs): mem_rd=0, mem_addr=0, conv_start=0, conv_inp=0, tri_valid=0, busy=0, done=0, err=0, skip_cnt=0; state=IDLE; buffer cleared.
- Reset is honoured in every state and aborts a batch mid-operation.
- The converter's active-high reset must be driven from ~reset at top level so both blocks reset on the same cycle.
- IDLE: on go=1, latch base_addr and tri_count, set tri_idx=0, clear err, set busy=1.
  - If tri_count=0, pulse done next cycle and stay IDLE.
  - Otherwise go to FETCH.
- FETCH (7 cycles): cycles k=0..5 assert mem_rd with mem_addr = base_addr + 6*tri_idx + k (mod 2^ADDR_W, wraps silently). Word k is captured into buf[k] in cycle k+1. mem_rd=0 in cycle 6.
- START (1 cycle): conv_start=1. The converter samples start at the end of this cycle.
- SHIFT (6 cycles): conv_inp = buf[k] in SHIFT cycle k. The register is loaded at the clock edge entering the cycle, so it is stable for the whole cycle the converter spends in the matching state.
- SHIFT timing: conv_inp holds buf[5] after SHIFT until overwritten.
- WAIT_FIN: wait for conv_finish=1, expected in the first WAIT_FIN cycle. Then go to PRESENT.
  - If finish is not seen within FIN_TIMEOUT cycles: set err=1, busy=0, pulse done, go to IDLE.
- PRESENT: tri_valid=1 until a cycle with tri_ready=1 (handshake). tri_valid must not drop before the handshake.
  - Next cycle: tri_idx+1. If it equals tri_count, go to IDLE, pulse done, busy=0. Else go to FETCH.
- Throughput: with go sampled in cycle G and tri_ready held 1, FETCH is G+1..G+7, START G+8, SHIFT G+9..G+14, WAIT_FIN G+15, tri_valid in G+16. Each following triangle's tri_valid is 16 cycles later.
- go while busy: ignored. conv_finish outside WAIT_FIN: ignored. tri_ready outside PRESENT: ignored.
- tri_count = 2^CNT_W-1 is legal; tri_idx must not overflow.

Optional Feature:
DEGEN_SKIP_EN:
- Defined: at the end of FETCH, compare the buffered vertices (x,y pairs). If any two of the three pairs are equal, skip START/SHIFT/WAIT_FIN/PRESENT for that triangle. Increment skip_cnt (saturating), advance tri_idx, go to FETCH or IDLE+done as normal. No converter activity and no tri_valid for a skipped triangle.
- Undefined: no comparison; every triangle is converted and presented; skip_cnt tied to 0.

Test Plan:
- Reset=0 for 2 cycles during SHIFT of triangle 0 -> all outputs 0 next cycle, IDLE, no tri_valid, no done.
- base=0x010, tri_count=1, mem[0x010..0x015]=1,2,3,4,5,6, tri_ready=1, go in cycle G -> tri_valid in G+16, converter x1..y3=1..6, done pulse G+17, busy low G+17.
- tri_count=3, base=0x3FC -> addresses wrap 0x3FC..0x3FF,0x000.. correctly; three handshakes spaced 16 cycles apart.
- tri_ready held 0 for 10 cycles in PRESENT -> tri_valid stays 1, no FETCH until handshake; go pulsed meanwhile is ignored.
- Converter finish forced to 0 -> err=1 and done pulse after FIN_TIMEOUT=4 cycles in WAIT_FIN; next go clears err.
- DEGEN_SKIP_EN, triangle 1 of 3 has (x1,y1)=(x3,y3)=(7,7) -> two tri_valid handshakes, skip_cnt=1, no conv_start for triangle 1.
